// File: rtl/gfm_switch_ctrl.sv
// Sequences a glitch-free clock mux between clk1 and clk2 with status handshake and post-switch dwell.
// Optional handover timeout (sticky err) is built when GFM_CTRL_TIMEOUT_EN is defined.
module gfm_switch_ctrl #(
  parameter int unsigned DWELL_CYC   = 16,
  parameter int unsigned TIMEOUT_CYC = 200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk1,
  input  logic rstn,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel,
  input  logic en1_st,
  input  logic en2_st,
  output logic busy,
  output logic done,
  output logic err,
  input  logic err_clr
);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT_OFF, WAIT_ON, DWELL} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync2_q;
  logic                   s1, s2;
  logic                   rst_meta_q;
  logic                   sel_q, sel_d;
  logic                   req_ready_q, req_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       dwell_q, dwell_d;
  logic                   accept;
  logic                   old_off, new_on;

`ifdef GFM_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic                   tmo_fire;
  logic                   err_q, err_d;
`else
  logic                   unused_cfg;
  assign unused_cfg = err_clr ^ (^CNT_W'(TIMEOUT_CYC));
`endif

  // Status synchronizers into the clk1 domain
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], en1_st};
      sync2_q <= {sync2_q[SYNC_STAGES-2:0], en2_st};
    end
  end

  assign s1 = sync1_q[SYNC_STAGES-1];
  assign s2 = sync2_q[SYNC_STAGES-1];

  // Reset-release synchronizer: rst_meta_q is stage one, req_ready_q acts as stage two
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) rst_meta_q <= 1'b0;
    else       rst_meta_q <= 1'b1;
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sel_q       <= 1'b1;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_q     <= '0;
`ifdef GFM_CTRL_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dwell_q     <= dwell_d;
`ifdef GFM_CTRL_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign accept  = req_valid && req_ready_q;
  assign old_off = sel_q ? !s2 : !s1;
  assign new_on  = sel_q ? s1 : s2;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    dwell_d = dwell_q;
`ifdef GFM_CTRL_TIMEOUT_EN
    tmo_d    = tmo_q;
    tmo_fire = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_sel != sel_q) begin
            sel_d   = req_sel;
            state_d = WAIT_OFF;
`ifdef GFM_CTRL_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_OFF: if (old_off) state_d = WAIT_ON;
      WAIT_ON: begin
        if (new_on) begin
          state_d = DWELL;
          done_d  = 1'b1;
          dwell_d = CNT_W'(DWELL_CYC);
        end
      end
      DWELL: begin
        if (dwell_q == CNT_W'(1)) state_d = IDLE;
        else                      dwell_d = dwell_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
`ifdef GFM_CTRL_TIMEOUT_EN
    // Handover limit spans both wait states; a completing WAIT_ON edge beats the limit
    if ((state_q == WAIT_OFF) || ((state_q == WAIT_ON) && !new_on)) begin
      tmo_d = tmo_q + CNT_W'(1);
      if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d  = IDLE;
        tmo_fire = 1'b1;
      end
    end
    err_d = tmo_fire | (err_q & !err_clr);
`endif
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE) && rst_meta_q;
  end

  assign req_ready = req_ready_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef GFM_CTRL_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_gfm_switch_ctrl.sv
// Self-checking bench for gfm_switch_ctrl: directed table, hand sequences, randomized transactions.
// Timeout scenarios are compiled in when GFM_CTRL_TIMEOUT_EN is defined.
module tb_gfm_switch_ctrl;
  localparam int unsigned S   = 2;
  localparam int unsigned D   = 16;
  localparam int unsigned TMO = 200;

  logic clk1 = 1'b0;
  logic rstn, req_valid, req_sel, en1_st, en2_st, err_clr;
  logic req_ready, sel, busy, done, err;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic sel_m  = 1'b1;
  logic err_m  = 1'b0;

  gfm_switch_ctrl #(.DWELL_CYC(D), .TIMEOUT_CYC(TMO), .SYNC_STAGES(S)) dut (
    .clk1(clk1), .rstn(rstn), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .sel(sel), .en1_st(en1_st), .en2_st(en2_st),
    .busy(busy), .done(done), .err(err), .err_clr(err_clr)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic rs;
    int   d_off;
    int   d_on;
    bit   noop;
    int   done_at;
    int   idle_at;
  } vec_t;

  task automatic tick();
    @(posedge clk1);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [4:0] exp);
    logic [4:0] act;
    act = {req_ready, sel, busy, done, err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d rdy/sel/busy/done/err got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  // One request: accept edge is relative edge 0; the path being dropped falls after
  // edge d_off, the new path rises after edge d_off+d_on.
  task automatic run_txn(input string nm, input logic rs, input int d_off, input int d_on,
                         input bit exp_noop, input int exp_done, input int exp_idle,
                         input int noise);
    req_sel   = rs;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    if (exp_noop) begin
      chk(nm, {1'b1, sel_m, 1'b0, 1'b1, err_m});
      tick();
      chk(nm, {1'b1, sel_m, 1'b0, 1'b0, err_m});
    end else begin
      sel_m = rs;
      for (int k = 0; k < exp_idle; k++) begin
        chk(nm, {1'b0, sel_m, 1'b1, (k == exp_done), err_m});
        if (k == d_off) begin
          if (rs) en2_st = 1'b0; else en1_st = 1'b0;
        end
        if (k == d_off + d_on) begin
          if (rs) en1_st = 1'b1; else en2_st = 1'b1;
        end
        if (noise == 1) begin
          if (k < exp_idle - 1) begin
            req_valid = 1'($urandom_range(0, 1));
            req_sel   = 1'($urandom_range(0, 1));
          end else begin
            req_valid = 1'b0;
          end
        end else if (noise == 2) begin
          req_sel   = ~rs;
          req_valid = (k == exp_idle - 1) ? 1'b1 : 1'((k % 2) == 1);
        end
        tick();
      end
      chk(nm, {1'b1, sel_m, 1'b0, 1'b0, err_m});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic rs;
    int   gap, d_off, d_on, e;

    vecs[0] = '{rs: 1'b1, d_off: 0, d_on: 0, noop: 1, done_at: 0,  idle_at: 0};
    vecs[1] = '{rs: 1'b0, d_off: 3, d_on: 4, noop: 0, done_at: 10, idle_at: 26};
    vecs[2] = '{rs: 1'b0, d_off: 0, d_on: 0, noop: 1, done_at: 0,  idle_at: 0};
    vecs[3] = '{rs: 1'b1, d_off: 1, d_on: 1, noop: 0, done_at: 5,  idle_at: 21};
    vecs[4] = '{rs: 1'b0, d_off: 5, d_on: 2, noop: 0, done_at: 10, idle_at: 26};
    vecs[5] = '{rs: 1'b1, d_off: 2, d_on: 6, noop: 0, done_at: 11, idle_at: 27};

    rstn = 1'b0; req_valid = 1'b0; req_sel = 1'b1; err_clr = 1'b0;
    en1_st = 1'b1; en2_st = 1'b0;
    repeat (3) tick();
    chk("reset", 5'b01000);
    rstn = 1'b1;
    tick();
    chk("rel_edge1", 5'b01000);
    tick();
    chk("rel_edge2", 5'b11000);
    repeat (3) begin
      tick();
      chk("idle_after_rel", 5'b11000);
    end

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].rs, vecs[i].d_off, vecs[i].d_on,
              vecs[i].noop, vecs[i].done_at, vecs[i].idle_at, 0);

    // Requests during the switch are ignored; the held one is taken on the first IDLE edge
    run_txn("dwell_hold", 1'b0, 1, 1, 0, 5, 21, 2);
    run_txn("dwell_accept", 1'b1, 2, 2, 0, 7, 23, 0);

    for (int t = 0; t < 25; t++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        err_clr = 1'($urandom_range(0, 1));
        tick();
        chk("rand_idle", {1'b1, sel_m, 1'b0, 1'b0, err_m});
      end
      err_clr = 1'b0;
      rs = 1'($urandom_range(0, 1));
      if (rs == sel_m) begin
        run_txn("rand_noop", rs, 0, 0, 1, 0, 0, 0);
      end else begin
        d_off = int'($urandom_range(1, 6));
        d_on  = int'($urandom_range(1, 6));
        e     = d_off + d_on + int'(S) + 1;
        run_txn("rand_switch", rs, d_off, d_on, 0, e, e + int'(D),
                int'($urandom_range(0, 1)));
      end
    end

    // Reset asserted while waiting for the new path to come up
    if (sel_m == 1'b0) run_txn("pre_rst", 1'b1, 1, 1, 0, 5, 21, 0);
    req_sel = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    sel_m = 1'b0;
    chk("rst_mid_acc", 5'b00100);
    en1_st = 1'b0;
    repeat (4) begin
      tick();
      chk("rst_mid_wait", 5'b00100);
    end
    rstn = 1'b0;
    #1;
    sel_m = 1'b1;
    chk("rst_mid_now", 5'b01000);
    en1_st = 1'b1; en2_st = 1'b0;
    tick();
    chk("rst_mid_hold", 5'b01000);
    rstn = 1'b1;
    tick();
    chk("rst_mid_rel1", 5'b01000);
    tick();
    chk("rst_mid_rel2", 5'b11000);
    repeat (4) begin
      tick();
      chk("rst_mid_nodone", 5'b11000);
    end

`ifdef GFM_CTRL_TIMEOUT_EN
    req_sel = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    sel_m = 1'b0;
    for (int k = 0; k < int'(TMO); k++) begin
      chk("tmo_wait", {1'b0, sel_m, 1'b1, 1'b0, err_m});
      tick();
    end
    err_m = 1'b1;
    chk("tmo_fire", {1'b1, sel_m, 1'b0, 1'b0, err_m});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_m = 1'b0;
    chk("tmo_clr", {1'b1, sel_m, 1'b0, 1'b0, err_m});
    en2_st = 1'b1;
    err_clr = 1'b1;
    req_sel = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    sel_m = 1'b1;
    for (int k = 0; k < int'(TMO); k++) begin
      chk("tmo2_wait", {1'b0, sel_m, 1'b1, 1'b0, err_m});
      tick();
    end
    err_m = 1'b1;
    chk("tmo2_setwins", {1'b1, sel_m, 1'b0, 1'b0, err_m});
    tick();
    err_m = 1'b0;
    err_clr = 1'b0;
    chk("tmo2_clr", {1'b1, sel_m, 1'b0, 1'b0, err_m});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
